// File: rtl/exhaustive_stim_sequencer.sv
// Exhaustive stimulus sequencer: walks every input pattern, holds each for SETTLE
// cycles, captures the DUT response and scores it against a golden response vector.
//
// state | meaning
// IDLE  | waiting for start; results of the last sweep are held
// HOLD  | pattern n_out is driven; settle timer runs, capture on terminal count
// DONE  | single-cycle end-of-sweep, done pulse and trojan_flag update
module exhaustive_stim_sequencer #(
   parameter int N_WIDTH   = 2,
   parameter int OUT_WIDTH = 1,
   parameter int SETTLE    = 1,
   parameter logic [(2**N_WIDTH)*OUT_WIDTH-1:0] GOLDEN = '0
) (
   input  logic                               CK,
   input  logic                               reset,
   input  logic                               start,
   input  logic [OUT_WIDTH-1:0]               dut_out,
   output logic [N_WIDTH-1:0]                 n_out,
   output logic                               busy,
   output logic                               done,
   output logic                               rsp_valid,
   output logic [N_WIDTH-1:0]                 rsp_pattern,
   output logic [OUT_WIDTH-1:0]               rsp_data,
   output logic [(2**N_WIDTH)*OUT_WIDTH-1:0]  resp_vec,
   output logic [N_WIDTH:0]                   mismatch_cnt,
   output logic                               trojan_flag
);

   localparam int NP = 2**N_WIDTH;
   localparam int RW = NP*OUT_WIDTH;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]      CNT_LOAD = CW'(SETTLE-1);
   localparam logic [N_WIDTH-1:0] LAST_PAT = N_WIDTH'(NP-1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HOLD = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]           state;
   logic [CW-1:0]        settle_cnt;
   logic [OUT_WIDTH-1:0] golden_sel;
   logic [RW-1:0]        resp_nxt;
   logic                 miss;
   logic [N_WIDTH:0]     mismatch_nxt;

   // Constant-slice decode of the current pattern keeps the part-selects static.
   always_comb begin
      golden_sel = '0;
      resp_nxt   = resp_vec;
      for (int p = 0; p < NP; p++) begin
         if (n_out == N_WIDTH'(p)) begin
            golden_sel                        = GOLDEN[p*OUT_WIDTH +: OUT_WIDTH];
            resp_nxt[p*OUT_WIDTH +: OUT_WIDTH] = dut_out;
         end
      end
   end

   assign miss         = (dut_out != golden_sel);
   assign mismatch_nxt = mismatch_cnt + (N_WIDTH+1)'(miss);

   // Settle timer counts down from SETTLE-1; zero marks the capture edge.
   always_ff @(posedge CK) begin
      if (reset) begin
         state        <= IDLE;
         settle_cnt   <= '0;
         n_out        <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_pattern  <= '0;
         rsp_data     <= '0;
         resp_vec     <= '0;
         mismatch_cnt <= '0;
         trojan_flag  <= 1'b0;
      end else begin
         done      <= 1'b0;
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state        <= HOLD;
                  n_out        <= '0;
                  settle_cnt   <= CNT_LOAD;
                  resp_vec     <= '0;
                  mismatch_cnt <= '0;
                  trojan_flag  <= 1'b0;
                  busy         <= 1'b1;
               end
            end
            HOLD: begin
               if (settle_cnt == '0) begin
                  resp_vec     <= resp_nxt;
                  mismatch_cnt <= mismatch_nxt;
                  rsp_valid    <= 1'b1;
                  rsp_pattern  <= n_out;
                  rsp_data     <= dut_out;
                  if (n_out == LAST_PAT) begin
                     state       <= DONE;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     trojan_flag <= (mismatch_nxt != '0);
                  end else begin
                     n_out      <= n_out + 1'b1;
                     settle_cnt <= CNT_LOAD;
                  end
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exhaustive_stim_sequencer.sv
// Bench for exhaustive_stim_sequencer: three configurations driven by a truth-table
// DUT model; expected sweep timing and results come from pattern arithmetic.
module tb_exhaustive_stim_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset        [3];
   logic       start        [3];
   logic       dut_out      [3];
   logic [1:0] n_out        [3];
   logic       busy         [3];
   logic       done         [3];
   logic       rsp_valid    [3];
   logic [1:0] rsp_pattern  [3];
   logic       rsp_data     [3];
   logic [3:0] resp_vec     [3];
   logic [2:0] mismatch_cnt [3];
   logic       trojan_flag  [3];
   logic [3:0] tt           [3];

   int n_checks = 0;
   int n_err    = 0;

   assign dut_out[0] = tt[0][n_out[0]];
   assign dut_out[1] = tt[1][n_out[1]];
   assign dut_out[2] = tt[2][n_out[2]];

   exhaustive_stim_sequencer #(.N_WIDTH(2), .OUT_WIDTH(1), .SETTLE(1), .GOLDEN(4'b0110)) u0 (
      .CK(clk), .reset(reset[0]), .start(start[0]), .dut_out(dut_out[0]), .n_out(n_out[0]),
      .busy(busy[0]), .done(done[0]), .rsp_valid(rsp_valid[0]), .rsp_pattern(rsp_pattern[0]),
      .rsp_data(rsp_data[0]), .resp_vec(resp_vec[0]), .mismatch_cnt(mismatch_cnt[0]),
      .trojan_flag(trojan_flag[0]));

   exhaustive_stim_sequencer #(.N_WIDTH(2), .OUT_WIDTH(1), .SETTLE(1), .GOLDEN(4'b0000)) u1 (
      .CK(clk), .reset(reset[1]), .start(start[1]), .dut_out(dut_out[1]), .n_out(n_out[1]),
      .busy(busy[1]), .done(done[1]), .rsp_valid(rsp_valid[1]), .rsp_pattern(rsp_pattern[1]),
      .rsp_data(rsp_data[1]), .resp_vec(resp_vec[1]), .mismatch_cnt(mismatch_cnt[1]),
      .trojan_flag(trojan_flag[1]));

   exhaustive_stim_sequencer #(.N_WIDTH(2), .OUT_WIDTH(1), .SETTLE(3), .GOLDEN(4'b0000)) u2 (
      .CK(clk), .reset(reset[2]), .start(start[2]), .dut_out(dut_out[2]), .n_out(n_out[2]),
      .busy(busy[2]), .done(done[2]), .rsp_valid(rsp_valid[2]), .rsp_pattern(rsp_pattern[2]),
      .rsp_data(rsp_data[2]), .resp_vec(resp_vec[2]), .mismatch_cnt(mismatch_cnt[2]),
      .trojan_flag(trojan_flag[2]));

   function automatic int settle_of(input int k);
      return (k == 2) ? 3 : 1;
   endfunction

   function automatic logic [3:0] golden_of(input int k);
      return (k == 0) ? 4'b0110 : 4'b0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cleared(input int k, input string tag);
      chk($sformatf("%s u%0d n_out", tag, k), 32'(n_out[k]), 0);
      chk($sformatf("%s u%0d busy", tag, k), 32'(busy[k]), 0);
      chk($sformatf("%s u%0d done", tag, k), 32'(done[k]), 0);
      chk($sformatf("%s u%0d rsp_valid", tag, k), 32'(rsp_valid[k]), 0);
      chk($sformatf("%s u%0d rsp_pattern", tag, k), 32'(rsp_pattern[k]), 0);
      chk($sformatf("%s u%0d rsp_data", tag, k), 32'(rsp_data[k]), 0);
      chk($sformatf("%s u%0d resp_vec", tag, k), 32'(resp_vec[k]), 0);
      chk($sformatf("%s u%0d mismatch_cnt", tag, k), 32'(mismatch_cnt[k]), 0);
      chk($sformatf("%s u%0d trojan_flag", tag, k), 32'(trojan_flag[k]), 0);
   endtask

   // One full sweep on instance k with truth table t; optional stray start at edge restart_at.
   task automatic do_sweep(input int k, input logic [3:0] t, input int restart_at, input bit keep_start);
      int s, last, mism, pat;
      s    = settle_of(k);
      last = 4 * s;
      mism = $countones(t ^ golden_of(k));
      tt[k]    = t;
      start[k] = 1'b1;
      @(posedge clk); #1;
      if (!keep_start) start[k] = 1'b0;
      chk($sformatf("start u%0d busy", k), 32'(busy[k]), 1);
      chk($sformatf("start u%0d n_out", k), 32'(n_out[k]), 0);
      chk($sformatf("start u%0d resp_vec", k), 32'(resp_vec[k]), 0);
      chk($sformatf("start u%0d mismatch_cnt", k), 32'(mismatch_cnt[k]), 0);
      chk($sformatf("start u%0d trojan_flag", k), 32'(trojan_flag[k]), 0);
      chk($sformatf("start u%0d rsp_valid", k), 32'(rsp_valid[k]), 0);
      for (int j = 1; j <= last; j++) begin
         @(posedge clk); #1;
         pat = (j < last) ? j / s : 3;
         chk($sformatf("u%0d e%0d n_out", k, j), 32'(n_out[k]), 32'(pat));
         chk($sformatf("u%0d e%0d busy", k, j), 32'(busy[k]), (j < last) ? 1 : 0);
         chk($sformatf("u%0d e%0d done", k, j), 32'(done[k]), (j < last) ? 0 : 1);
         chk($sformatf("u%0d e%0d rsp_valid", k, j), 32'(rsp_valid[k]), (j % s == 0) ? 1 : 0);
         if (j % s == 0) begin
            chk($sformatf("u%0d e%0d rsp_pattern", k, j), 32'(rsp_pattern[k]), 32'(j / s - 1));
            chk($sformatf("u%0d e%0d rsp_data", k, j), 32'(rsp_data[k]), 32'(t[j / s - 1]));
         end
         if (j == last) begin
            chk($sformatf("done u%0d resp_vec", k), 32'(resp_vec[k]), 32'(t));
            chk($sformatf("done u%0d mismatch_cnt", k), 32'(mismatch_cnt[k]), 32'(mism));
            chk($sformatf("done u%0d trojan_flag", k), 32'(trojan_flag[k]), (mism != 0) ? 1 : 0);
         end
         if (j == restart_at) start[k] = 1'b1;
         else if (j == restart_at + 1 && !keep_start) start[k] = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("post u%0d done", k), 32'(done[k]), 0);
      chk($sformatf("post u%0d busy", k), 32'(busy[k]), 0);
      chk($sformatf("post u%0d n_out", k), 32'(n_out[k]), 3);
      chk($sformatf("post u%0d rsp_valid", k), 32'(rsp_valid[k]), 0);
      chk($sformatf("post u%0d resp_vec", k), 32'(resp_vec[k]), 32'(t));
      chk($sformatf("post u%0d mismatch_cnt", k), 32'(mismatch_cnt[k]), 32'(mism));
      chk($sformatf("post u%0d trojan_flag", k), 32'(trojan_flag[k]), (mism != 0) ? 1 : 0);
   endtask

   initial begin
      int k;
      logic [31:0] r;
      for (int i = 0; i < 3; i++) begin
         reset[i] = 1'b1;
         start[i] = 1'b0;
         tt[i]    = 4'b0000;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk_cleared(i, "reset");
      for (int i = 0; i < 3; i++) reset[i] = 1'b0;

      // XOR DUT against matching golden, then against all-zero golden, then AND with SETTLE=3
      do_sweep(0, 4'b0110, -1, 1'b0);
      do_sweep(1, 4'b0110, -1, 1'b0);
      do_sweep(2, 4'b1000, -1, 1'b0);

      // stray start at pattern 2 must not disturb the sweep
      do_sweep(0, 4'b0110, 2, 1'b0);

      // reset during HOLD at pattern 1
      tt[0]    = 4'b1111;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      @(posedge clk); #1;
      chk("abort pre n_out", 32'(n_out[0]), 1);
      chk("abort pre rsp_data", 32'(rsp_data[0]), 1);
      reset[0] = 1'b1;
      @(posedge clk); #1;
      reset[0] = 1'b0;
      chk_cleared(0, "abort");
      for (int j = 0; j < 6; j++) begin
         @(posedge clk); #1;
         chk($sformatf("abort idle%0d done", j), 32'(done[0]), 0);
         chk($sformatf("abort idle%0d busy", j), 32'(busy[0]), 0);
      end
      do_sweep(0, 4'b0110, -1, 1'b0);

      // reset and start together: reset wins
      reset[0] = 1'b1;
      start[0] = 1'b1;
      @(posedge clk); #1;
      reset[0] = 1'b0;
      start[0] = 1'b0;
      chk_cleared(0, "rst_start");

      // start held high: two back-to-back sweeps with one IDLE cycle between
      do_sweep(0, 4'b1001, -1, 1'b1);
      do_sweep(0, 4'b0111, -1, 1'b0);

      // random truth tables on random instances
      for (int n = 0; n < 8; n++) begin
         k = $urandom_range(0, 2);
         r = $urandom;
         do_sweep(k, r[3:0], -1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
